// File: rtl/imc_sched_if.sv
// imc_sched_if: requester, imc-core and response signals of the imc scheduler
interface imc_sched_if #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4
);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a, req_b, req_c, req_d;
   logic                  imc_start;
   logic [WIDTH-1:0]      imc_aIn, imc_bIn, imc_cIn, imc_dIn;
   logic                  imc_ready;
   logic [WIDTH-1:0]      imc_aOut, imc_bOut, imc_cOut, imc_dOut;
   logic                  imc_aOut_sign, imc_bOut_sign, imc_cOut_sign, imc_dOut_sign;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IW-1:0]         rsp_id;
   logic [WIDTH-1:0]      rsp_a, rsp_b, rsp_c, rsp_d;
   logic                  rsp_a_sign, rsp_b_sign, rsp_c_sign, rsp_d_sign;
   logic                  rsp_err;

   modport slave (
      input  req_valid, req_a, req_b, req_c, req_d,
      input  imc_ready, imc_aOut, imc_bOut, imc_cOut, imc_dOut,
      input  imc_aOut_sign, imc_bOut_sign, imc_cOut_sign, imc_dOut_sign,
      input  rsp_ready,
      output req_ready, imc_start, imc_aIn, imc_bIn, imc_cIn, imc_dIn,
      output rsp_valid, rsp_id, rsp_a, rsp_b, rsp_c, rsp_d,
      output rsp_a_sign, rsp_b_sign, rsp_c_sign, rsp_d_sign, rsp_err
   );

   modport master (
      output req_valid, req_a, req_b, req_c, req_d,
      output imc_ready, imc_aOut, imc_bOut, imc_cOut, imc_dOut,
      output imc_aOut_sign, imc_bOut_sign, imc_cOut_sign, imc_dOut_sign,
      output rsp_ready,
      input  req_ready, imc_start, imc_aIn, imc_bIn, imc_cIn, imc_dIn,
      input  rsp_valid, rsp_id, rsp_a, rsp_b, rsp_c, rsp_d,
      input  rsp_a_sign, rsp_b_sign, rsp_c_sign, rsp_d_sign, rsp_err
   );
endinterface

// File: rtl/imc_sched.sv
// imc_sched: round-robin sharing of one imc core among NREQ requesters; IMC_SCHED_WATCHDOG_EN adds a WAIT-state watchdog
module imc_sched #(
   parameter int WIDTH   = 16,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input logic        clk,
   input logic        rst,
   imc_sched_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t                          state, state_nx;
   logic [IW-1:0]                   last_grant, grant, idx, id_q;
   logic                            any, timeout;
   logic [NREQ-1:0][3:0][WIDTH-1:0] req_ops;
   logic [3:0][WIDTH-1:0]           op_q, res_q;
   logic [3:0]                      sign_q;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
      $error("imc_sched: unsupported parameters");
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_ops
      assign req_ops[i] = {bus.req_d[i*WIDTH +: WIDTH], bus.req_c[i*WIDTH +: WIDTH],
                           bus.req_b[i*WIDTH +: WIDTH], bus.req_a[i*WIDTH +: WIDTH]};
   end

   // round-robin pick: scan downward so the nearest index after last_grant wins
   always_comb begin
      grant = last_grant;
      idx   = '0;
      any   = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last_grant) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

   // next state: one job in flight, response must be consumed before the next grant
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = any ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = (bus.imc_ready || timeout) ? RESP : WAIT;
         default: state_nx = bus.rsp_ready ? IDLE : RESP;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // operand latch on grant, result capture on core completion (zeros on timeout)
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= IW'(NREQ - 1);
         id_q       <= '0;
         op_q       <= '0;
         res_q      <= '0;
         sign_q     <= '0;
      end else begin
         if (state == IDLE && any) begin
            last_grant <= grant;
            id_q       <= grant;
            op_q       <= req_ops[grant];
         end
         if (state == WAIT && (bus.imc_ready || timeout)) begin
            res_q  <= bus.imc_ready ? {bus.imc_dOut, bus.imc_cOut, bus.imc_bOut, bus.imc_aOut} : '0;
            sign_q <= bus.imc_ready ? {bus.imc_dOut_sign, bus.imc_cOut_sign,
                                       bus.imc_bOut_sign, bus.imc_aOut_sign} : '0;
         end
      end
   end

`ifdef IMC_SCHED_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] cnt;
   logic          err_q;
   assign timeout = state == WAIT && !bus.imc_ready && cnt == CW'(TIMEOUT - 1);
   // count WAIT cycles from zero; the error flag follows how WAIT was left
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         cnt <= state == WAIT ? cnt + 1'b1 : '0;
         if (state == WAIT && (bus.imc_ready || timeout)) err_q <= timeout;
      end
   end
   assign bus.rsp_err = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req_ready = (state == IDLE && any && !rst) ? NREQ'(1) << grant : '0;
   assign bus.imc_start = state == ISSUE;
   assign {bus.imc_dIn, bus.imc_cIn, bus.imc_bIn, bus.imc_aIn} = op_q;
   assign bus.rsp_valid = state == RESP;
   assign bus.rsp_id    = id_q;
   assign {bus.rsp_d, bus.rsp_c, bus.rsp_b, bus.rsp_a} = res_q;
   assign {bus.rsp_d_sign, bus.rsp_c_sign, bus.rsp_b_sign, bus.rsp_a_sign} = sign_q;
endmodule

// File: tb/tb_imc_sched.sv
// tb_imc_sched: scoreboard bench for imc_sched with a stub imc core
`timescale 1ns/1ps
module tb_imc_sched;
   typedef struct packed {
      logic [1:0]       id;
      logic [3:0][15:0] d;
      logic [3:0]       s;
      logic             err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imc_sched_if #(.WIDTH(16), .NREQ(4)) bus();
   imc_sched #(.WIDTH(16), .NREQ(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   int               checks = 0, errors = 0;
   int               n_rsp = 0, n_gnt = 0, n_start = 0;
   int               lat = 2;
   bit               use_fixed = 1'b0, never_ready = 1'b0;
   rsp_t             exp_q[$];
   logic [1:0]       gnt_q[$];
   rsp_t             mon_e;
   logic [3:0][15:0] ops [4];

   function automatic rsp_t model(logic [1:0] id, logic [3:0][15:0] o);
      rsp_t r;
      r.id   = id;
      r.err  = 1'b0;
      r.d[0] = o[0] ^ 16'h1234;
      r.d[1] = o[1] + 16'd3;
      r.d[2] = ~o[2];
      r.d[3] = o[3] - 16'd1;
      r.s    = {o[3][0], o[2][0], o[1][0], o[0][0]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load_ops();
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*16 +: 16] = ops[i][0];
         bus.req_b[i*16 +: 16] = ops[i][1];
         bus.req_c[i*16 +: 16] = ops[i][2];
         bus.req_d[i*16 +: 16] = ops[i][3];
      end
   endtask

   task automatic wait_grant(input int target);
      for (int k = 0; k < 200 && n_gnt < target; k++) tick();
      chk("grant_count", n_gnt, target);
   endtask

   task automatic wait_rsp(input int target);
      for (int k = 0; k < 400 && n_rsp < target; k++) tick();
      chk("rsp_count", n_rsp, target);
   endtask

   task automatic do_job(input logic [1:0] id, input rsp_t e);
      gnt_q.push_back(id);
      exp_q.push_back(e);
      bus.req_valid[id] = 1'b1;
      wait_grant(n_gnt + 1);
      bus.req_valid[id] = 1'b0;
      wait_rsp(n_rsp + 1);
   endtask

   // monitor: counts starts, checks grants and completed responses against the queues
   always @(negedge clk) begin
      if (bus.imc_start) n_start++;
      if (bus.req_ready != 4'b0) begin
         n_gnt++;
         if (gnt_q.size() == 0) chk("unexpected_grant", bus.req_ready, 0);
         else chk("grant", bus.req_ready, 4'b1 << gnt_q.pop_front());
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("rsp_id", bus.rsp_id, mon_e.id);
            chk("rsp_data", {bus.rsp_d, bus.rsp_c, bus.rsp_b, bus.rsp_a}, mon_e.d);
            chk("rsp_sign", {bus.rsp_d_sign, bus.rsp_c_sign, bus.rsp_b_sign, bus.rsp_a_sign}, mon_e.s);
            chk("rsp_err", bus.rsp_err, mon_e.err);
         end
      end
   end

   // stub imc core: answers each start after lat cycles unless told to stay silent
   initial begin
      logic [3:0][15:0] o;
      rsp_t r;
      bus.imc_ready = 1'b0;
      {bus.imc_dOut, bus.imc_cOut, bus.imc_bOut, bus.imc_aOut} = '0;
      {bus.imc_dOut_sign, bus.imc_cOut_sign, bus.imc_bOut_sign, bus.imc_aOut_sign} = '0;
      forever begin
         @(negedge clk);
         if (bus.imc_start && !never_ready) begin
            o = {bus.imc_dIn, bus.imc_cIn, bus.imc_bIn, bus.imc_aIn};
            r = model(2'd0, o);
            if (use_fixed) begin
               r.d = {16'h0100, 16'h0080, 16'h0100, 16'h0000};
               r.s = 4'b1000;
            end
            repeat (lat - 1) @(negedge clk);
            {bus.imc_dOut, bus.imc_cOut, bus.imc_bOut, bus.imc_aOut} = r.d;
            {bus.imc_dOut_sign, bus.imc_cOut_sign, bus.imc_bOut_sign, bus.imc_aOut_sign} = r.s;
            bus.imc_ready = 1'b1;
            @(negedge clk);
            bus.imc_ready = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation hung");
   end

   initial begin
      rsp_t e;
      int   s0, g0, r0, k;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         ops[i] = {16'(16'h0F00 + i*5), 16'(16'h3000 ^ i), 16'(16'h2000 + i*3), 16'(16'h1000 + i)};
      load_ops();

      // reset: three cycles, every output low
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_imc_start", bus.imc_start, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", {bus.rsp_d, bus.rsp_c, bus.rsp_b, bus.rsp_a}, 0);
      chk("rst_rsp_sign", {bus.rsp_d_sign, bus.rsp_c_sign, bus.rsp_b_sign, bus.rsp_a_sign}, 0);
      chk("rst_imc_in", {bus.imc_dIn, bus.imc_cIn, bus.imc_bIn, bus.imc_aIn}, 0);
      rst = 1'b0;

      // lone request from requester 2
      do_job(2'd2, model(2'd2, ops[2]));

      // requester 0 with the reference operands and reference core results
      ops[0] = {16'h0000, 16'h0100, 16'h0200, 16'h0200};
      load_ops();
      use_fixed = 1'b1;
      e.id = 2'd0; e.err = 1'b0; e.s = 4'b1000;
      e.d = {16'h0100, 16'h0080, 16'h0100, 16'h0000};
      do_job(2'd0, e);
      use_fixed = 1'b0;

      // response held 10 cycles; another requester waits and then withdraws
      e = model(2'd1, ops[1]);
      gnt_q.push_back(2'd1);
      exp_q.push_back(e);
      bus.rsp_ready = 1'b0;
      bus.req_valid[1] = 1'b1;
      wait_grant(n_gnt + 1);
      bus.req_valid[1] = 1'b0;
      for (k = 0; k < 100 && !bus.rsp_valid; k++) tick();
      chk("stall_rsp_valid_seen", bus.rsp_valid, 1);
      bus.req_valid[3] = 1'b1;
      s0 = n_start;
      repeat (10) begin
         tick();
         chk("stall_rsp_valid", bus.rsp_valid, 1);
         chk("stall_rsp_id", bus.rsp_id, e.id);
         chk("stall_rsp_data", {bus.rsp_d, bus.rsp_c, bus.rsp_b, bus.rsp_a}, e.d);
      end
      chk("stall_no_start", n_start, s0);
      bus.req_valid[3] = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_rsp(n_rsp + 1);

      // all requesters busy after reset: grants 0,1,2,3,0 with a 5-cycle core
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      lat = 5;
      for (int i = 0; i < 5; i++) begin
         gnt_q.push_back(2'(i % 4));
         exp_q.push_back(model(2'(i % 4), ops[i % 4]));
      end
      s0 = n_start;
      g0 = n_gnt;
      r0 = n_rsp;
      bus.req_valid = 4'hF;
      wait_grant(g0 + 5);
      bus.req_valid = '0;
      wait_rsp(r0 + 5);
      chk("rr_start_count", n_start - s0, 5);

      // reset during WAIT: the late core answer must not produce a response
      r0 = n_rsp;
      gnt_q.push_back(2'd2);
      bus.req_valid[2] = 1'b1;
      wait_grant(n_gnt + 1);
      bus.req_valid[2] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      chk("abort_rsp_valid", bus.rsp_valid, 0);
      chk("abort_rsp_count", n_rsp, r0);
      gnt_q.push_back(2'd0);
      exp_q.push_back(model(2'd0, ops[0]));
      bus.req_valid = 4'hF;
      wait_grant(n_gnt + 1);
      bus.req_valid = '0;
      wait_rsp(r0 + 1);

`ifdef IMC_SCHED_WATCHDOG_EN
      // silent core: watchdog ends WAIT after 16 cycles with an error response
      never_ready = 1'b1;
      e.id = 2'd1; e.err = 1'b1; e.s = '0; e.d = '0;
      gnt_q.push_back(2'd1);
      exp_q.push_back(e);
      bus.req_valid[1] = 1'b1;
      wait_grant(n_gnt + 1);
      bus.req_valid[1] = 1'b0;
      tick();
      for (k = 0; k < 100 && !bus.rsp_valid; k++) tick();
      chk("wd_cycles", k, 16);
      wait_rsp(n_rsp + 1);
      never_ready = 1'b0;
`endif

      repeat (3) tick();
      chk("exp_q_empty", exp_q.size(), 0);
      chk("gnt_q_empty", gnt_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imc_sched.md
IMC_SCHED -- requirements
Module: imc_sched

Interface
REQ-001 Parameter WIDTH, default 16, operand/result word width (Q8.8 magnitude at 16).
REQ-002 Parameter NREQ, default 4, number of requesters sharing one imc core; range 2..8.
REQ-003 Parameter TIMEOUT, default 1024, watchdog limit in cycles while waiting on imc_ready.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request valid; held until accepted.
REQ-007 req_ready  out  NREQ  one-hot accept pulse; at most one bit high per cycle.
REQ-008 req_a/b/c/d  in  NREQ*WIDTH each  packed matrix operands; slice i belongs to requester i.
REQ-009 imc_start  out  1  start pulse to imc core.
REQ-010 imc_aIn/bIn/cIn/dIn  out  WIDTH each  operands to imc core.
REQ-011 imc_ready  in  1  imc core result-valid indication.
REQ-012 imc_aOut/bOut/cOut/dOut  in  WIDTH each; imc_aOut_sign..imc_dOut_sign  in  1 each  imc results.
REQ-013 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-014 rsp_id  out  clog2(NREQ)  index of requester owning the response.
REQ-015 rsp_a/b/c/d  out  WIDTH each; rsp_a_sign..rsp_d_sign  out  1 each  captured results.
REQ-016 rsp_err  out  1  response terminated by watchdog (only with macro, else tied 0).

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-018 IDLE: if any req_valid, grant round-robin starting at index (last_grant+1) mod NREQ, pulse req_ready[grant], latch that requester's operands and id, go ISSUE.
REQ-019 IDLE with no req_valid: remain IDLE, req_ready all 0, last_grant unchanged.
REQ-020 ISSUE: imc_start=1 for exactly one cycle, go WAIT; imc_*In driven from latched operands from ISSUE through end of WAIT.
REQ-021 WAIT: imc_ready ignored during the ISSUE cycle; first cycle imc_ready=1 in WAIT captures all imc outputs and signs into rsp registers, go RESP.
REQ-022 RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then go IDLE same edge.
REQ-023 Minimum latency accept->rsp_valid: 3 cycles plus imc core latency; next grant earliest the cycle after the response handshake.
REQ-024 Requesters never starve: with all req_valid high, grants cycle 0,1,..,NREQ-1,0.
REQ-025 req_valid dropping before grant: no grant, no error; operands never sampled except on grant cycle.
REQ-026 req_valid high in any state other than IDLE: no req_ready asserted.
REQ-027 Results passed bit-exact; no arithmetic on data; rsp_id width clog2(NREQ).

Reset
REQ-028 rst high at any edge: state IDLE, last_grant=NREQ-1 (first grant to requester 0), imc_start=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_* data/sign/id=0.
REQ-029 rst mid-job abandons job; a late imc_ready after reset is ignored (state IDLE).

Configuration
REQ-030 Macro IMC_SCHED_WATCHDOG_EN defined: cycle counter cleared on entering WAIT; reaching TIMEOUT in WAIT without imc_ready goes RESP with rsp_err=1 and rsp data/signs=0.
REQ-031 Macro undefined: no counter, WAIT held indefinitely, rsp_err constant 0.

Verification
REQ-032 Reset: rst high 3 cycles -> all outputs 0, state IDLE; first request from req 2 alone -> req_ready=0b0100.
REQ-033 Real imc core, req 0 operands a=0x0200,b=0x0200,c=0x0100,d=0x0000 -> rsp_id=0, rsp_a=0x0000, rsp_b=0x0100 sign0, rsp_c=0x0080 sign0, rsp_d=0x0100 sign1.
REQ-034 All 4 req_valid held high, stub core 5-cycle latency, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one imc_start per job.
REQ-035 rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, no new req_ready, no imc_start.
REQ-036 With IMC_SCHED_WATCHDOG_EN, TIMEOUT=16, stub never asserts imc_ready -> rsp_valid with rsp_err=1 exactly 16 cycles after WAIT entry.
REQ-037 rst asserted in WAIT then stub asserts imc_ready -> no rsp_valid; next request served normally from requester 0.
